// File: rtl/mips_pkg.sv
// Shared MIPS definitions: ALU op encodings, common widths and the
// multiplier sequencer state encoding.
package mips_pkg;

  localparam int unsigned MIPS_XLEN = 32;
  localparam int unsigned ALU_OP_W  = 4;
  localparam int unsigned SHAMT_W   = 5;
  localparam int unsigned ITER_W    = 6;

  localparam logic [ALU_OP_W-1:0] ALU_AND    = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_OR     = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_NOR    = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_ADD    = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_SUB    = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_SHIFTL = 4'b1110;
  localparam logic [ALU_OP_W-1:0] ALU_SHIFTR = 4'b1100;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ADD   = 3'd2,
    SHL   = 3'd3,
    SHR   = 3'd4,
    DONE  = 3'd5
  } mult_state_t;

endpackage : mips_pkg

// File: rtl/alu_mult_sequencer_alu.sv
// Private copy of the core's 32-bit ALU; purely combinational.
module alu_mult_sequencer_alu
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = MIPS_XLEN
) (
  input  logic [ALU_OP_W-1:0] op_i,
  input  logic [WIDTH-1:0]    a_i,
  input  logic [WIDTH-1:0]    b_i,
  input  logic [SHAMT_W-1:0]  shamt_i,
  output logic [WIDTH-1:0]    result_c,
  output logic                zero_c
);

  always_comb begin
    result_c = '0;
    case (op_i)
      ALU_AND:    result_c = a_i & b_i;
      ALU_OR:     result_c = a_i | b_i;
      ALU_NOR:    result_c = ~(a_i | b_i);
      ALU_ADD:    result_c = a_i + b_i;
      ALU_SUB:    result_c = a_i - b_i;
      ALU_SHIFTL: result_c = a_i << shamt_i;
      ALU_SHIFTR: result_c = a_i >> shamt_i;
      default:    result_c = '0;
    endcase
  end

  assign zero_c = (result_c == '0);

endmodule : alu_mult_sequencer_alu

// File: rtl/alu_mult_sequencer.sv
// Multi-cycle unsigned multiplier (low 32 bits of A*B) that steps a private
// ALU through shift-add iterations; the pipeline stalls while busy is high.
module alu_mult_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MIPS_XLEN,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] multiplicand,
  input  logic [DATA_WIDTH-1:0] multiplier,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] product
);

  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(DATA_WIDTH);

  mult_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] prod_q, prod_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplr_q, mplr_d;
  logic [ITER_W-1:0]     iter_q, iter_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] product_q, product_d;

  logic [ALU_OP_W-1:0]   alu_op;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [SHAMT_W-1:0]    alu_shamt;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_zero;

  alu_mult_sequencer_alu #(
    .WIDTH (DATA_WIDTH)
  ) u_alu (
    .op_i     (alu_op),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .shamt_i  (alu_shamt),
    .result_c (alu_result),
    .zero_c   (alu_zero)
  );

  // Next-state, datapath updates and ALU operand steering.
  always_comb begin
    state_d   = state_q;
    prod_d    = prod_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    iter_d    = iter_q;
    alu_op    = ALU_OR;
    alu_a     = '0;
    alu_b     = '0;
    alu_shamt = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = multiplicand;
          mplr_d  = multiplier;
          prod_d  = '0;
          iter_d  = '0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        alu_op = ALU_OR;
        alu_a  = mplr_q;
        if ((EARLY_EXIT && alu_zero) || (iter_q == ITER_MAX)) begin
          state_d = DONE;
        end else if (mplr_q[0]) begin
          state_d = ADD;
        end else begin
          state_d = SHL;
        end
      end
      ADD: begin
        alu_op  = ALU_ADD;
        alu_a   = prod_q;
        alu_b   = mcand_q;
        prod_d  = alu_result;
        state_d = SHL;
      end
      SHL: begin
        alu_op    = ALU_SHIFTL;
        alu_a     = mcand_q;
        alu_shamt = SHAMT_W'(1);
        mcand_d   = alu_result;
        state_d   = SHR;
      end
      SHR: begin
        alu_op    = ALU_SHIFTR;
        alu_a     = mplr_q;
        alu_shamt = SHAMT_W'(1);
        mplr_d    = alu_result;
        iter_d    = iter_q + ITER_W'(1);
        state_d   = CHECK;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the upcoming state so they line up with it.
    busy_d    = !(state_d inside {IDLE, DONE});
    done_d    = (state_d == DONE);
    product_d = (state_d == DONE) ? prod_q : product_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      prod_q    <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      iter_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      prod_q    <= prod_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      iter_q    <= iter_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule : alu_mult_sequencer
